// File: rtl/alu_exec_seq.sv
// EX-stage execute unit: single-cycle logic/arithmetic ops, iterative one-bit-per-cycle shifts,
// valid/ready handshakes on the request and result sides.
module alu_exec_seq #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_alu_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_ovf,
  output logic              o_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_SLL  = 4'd0,  OP_SRL  = 4'd1,  OP_SRA = 4'd2,
    OP_ADD  = 4'd3,  OP_ADDU = 4'd4,  OP_SUB = 4'd5, OP_SUBU = 4'd6,
    OP_AND  = 4'd7,  OP_OR   = 4'd8,  OP_XOR = 4'd9, OP_NOR  = 4'd10,
    OP_SLT  = 4'd11, OP_SLTU = 4'd12, OP_LUI = 4'd13
  } alu_op_e;

  state_e              state_q, state_d;
  alu_op_e             op_q, op_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                illegal_q, illegal_d;

  alu_op_e             op_in;
  logic [SHAMT_W-1:0]  amt;
  logic                is_shift;
  logic [DATA_W-1:0]   sum, diff, alu_res, work_shifted;
  logic                alu_ovf, alu_ill;

  assign op_in    = alu_op_e'(i_alu_op);
  assign amt      = i_b[SHAMT_W-1:0];
  assign is_shift = (op_in == OP_SLL) || (op_in == OP_SRL) || (op_in == OP_SRA);
  assign sum      = i_a + i_b;
  assign diff     = i_a - i_b;

  // Single-cycle datapath; for shifts it only covers the amount-0 pass-through.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (op_in)
      OP_SLL, OP_SRL, OP_SRA: alu_res = i_a;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (sum[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (diff[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_SUBU: alu_res = diff;
      OP_AND:  alu_res = i_a & i_b;
      OP_OR:   alu_res = i_a | i_b;
      OP_XOR:  alu_res = i_a ^ i_b;
      OP_NOR:  alu_res = ~(i_a | i_b);
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, i_a < i_b};
      OP_LUI:  alu_res = {i_b[15:0], {(DATA_W-16){1'b0}}};
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  work_shifted = {work_q[DATA_W-2:0], 1'b0};
      OP_SRL:  work_shifted = {1'b0, work_q[DATA_W-1:1]};
      default: work_shifted = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          op_d = op_in;
          if (is_shift && (amt != '0)) begin
            state_d = S_SHIFT;
            cnt_d   = amt;
            work_d  = i_a;
          end else begin
            state_d   = S_DONE;
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            ovf_d     = alu_ovf;
            illegal_d = alu_ill;
          end
        end
      end
      S_SHIFT: begin
        work_d = work_shifted;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          state_d   = S_DONE;
          result_d  = work_shifted;
          zero_d    = (work_shifted == '0);
          ovf_d     = 1'b0;
          illegal_d = 1'b0;
        end
      end
      S_DONE: begin
        if (i_res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_SLL;
      work_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_valid   = (state_q == S_DONE);
  assign o_result  = result_q;
  assign o_zero    = zero_q;
  assign o_ovf     = ovf_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed vector table, hand-written handshake/reset
// sequences, and random ops checked against an arithmetic reference model.
module tb_alu_exec_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_alu_op;
  logic [31:0] i_a, i_b;
  logic        o_valid;
  logic        i_res_ready;
  logic [31:0] o_result;
  logic        o_zero, o_ovf, o_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_seq #(.DATA_W(32), .SHAMT_W(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_op(i_alu_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid),
    .i_res_ready(i_res_ready), .o_result(o_result), .o_zero(o_zero),
    .o_ovf(o_ovf), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        ill;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model from the op definitions, using wide signed arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic ovf, output logic ill,
                       output int lat);
    longint sa, sb, s;
    int amt;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    amt = int'(b[4:0]);
    res = 32'h0; ovf = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      4'd0:  begin res = a << amt; lat = 1 + amt; end
      4'd1:  begin res = a >> amt; lat = 1 + amt; end
      4'd2:  begin res = $unsigned($signed(a) >>> amt); lat = 1 + amt; end
      4'd3:  begin s = sa + sb; res = a + b; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd4:  res = a + b;
      4'd5:  begin s = sa - sb; res = a - b; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd6:  res = a - b;
      4'd7:  res = a & b;
      4'd8:  res = a | b;
      4'd9:  res = a ^ b;
      4'd10: res = ~(a | b);
      4'd11: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: res = (a < b) ? 32'd1 : 32'd0;
      4'd13: res = {b[15:0], 16'h0};
      default: ill = 1'b1;
    endcase
  endtask

  // Issue one op with i_res_ready=1, measure latency, check outputs and the return to IDLE.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ovf,
                       input logic exp_ill, input int exp_lat);
    int lat;
    check({name, " ready_before"}, {31'b0, o_ready}, 32'd1);
    i_valid = 1'b1; i_alu_op = op; i_a = a; i_b = b; i_res_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
      if (!o_valid && o_ready) begin
        check({name, " ready_low_while_busy"}, {31'b0, o_ready}, 32'd0);
        break;
      end
    end while (!o_valid && lat < 40);
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, o_result, exp_res);
    check({name, " zero"}, {31'b0, o_zero}, {31'b0, exp_res == 32'h0});
    check({name, " ovf"}, {31'b0, o_ovf}, {31'b0, exp_ovf});
    check({name, " illegal"}, {31'b0, o_illegal}, {31'b0, exp_ill});
    @(negedge i_clk);
    check({name, " valid_cleared"}, {31'b0, o_valid}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] r, held;
    logic        ov, il;
    int          lt;

    vecs.push_back('{4'd3,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd4,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd5,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd5,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd2,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 5});
    vecs.push_back('{4'd1,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 5});
    vecs.push_back('{4'd0,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 32});
    vecs.push_back('{4'd14, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd0,  32'h000000A5, 32'hFFFFFFE0, 32'h000000A5, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd10, 32'h0F0F0000, 32'h000000F0, 32'hF0F0FF0F, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd0,  32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 2});

    i_rst = 1'b1; i_valid = 1'b0; i_alu_op = 4'd0; i_a = '0; i_b = '0; i_res_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    check("reset ready",   {31'b0, o_ready}, 32'd1);
    check("reset valid",   {31'b0, o_valid}, 32'd0);
    check("reset result",  o_result, 32'h0);
    check("reset flags",   {29'b0, o_zero, o_ovf, o_illegal}, 32'h0);

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].res, vecs[i].ovf, vecs[i].ill, vecs[i].lat);

    // Result held in DONE while the consumer stalls; new requests are ignored.
    i_valid = 1'b1; i_alu_op = 4'd3; i_a = 32'h7FFFFFFF; i_b = 32'h1; i_res_ready = 1'b0;
    @(negedge i_clk);
    held = o_result;
    check("hold first result", held, 32'h80000000);
    for (int k = 0; k < 3; k++) begin
      i_alu_op = 4'd8; i_a = $urandom; i_b = $urandom;
      @(negedge i_clk);
      check($sformatf("hold%0d valid", k), {31'b0, o_valid}, 32'd1);
      check($sformatf("hold%0d ready", k), {31'b0, o_ready}, 32'd0);
      check($sformatf("hold%0d result", k), o_result, 32'h80000000);
      check($sformatf("hold%0d flags", k), {29'b0, o_zero, o_ovf, o_illegal}, 32'b010);
    end
    i_valid = 1'b0; i_res_ready = 1'b1;
    @(negedge i_clk);
    check("hold release ready", {31'b0, o_ready}, 32'd1);
    check("hold release valid", {31'b0, o_valid}, 32'd0);
    check("hold release keeps result", o_result, 32'h80000000);

    // Reset in the middle of SLL by 10 aborts the op.
    i_valid = 1'b1; i_alu_op = 4'd0; i_a = 32'h1; i_b = 32'd10;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("abort ready",  {31'b0, o_ready}, 32'd1);
    check("abort valid",  {31'b0, o_valid}, 32'd0);
    check("abort result", o_result, 32'h0);
    check("abort flags",  {29'b0, o_zero, o_ovf, o_illegal}, 32'h0);
    repeat (12) begin
      @(negedge i_clk);
      check("abort stays idle", {30'b0, o_valid, o_ready}, 32'b01);
    end
    do_op("lui after abort", 4'd13, 32'hDEADBEEF, 32'h00001234, 32'h12340000, 1'b0, 1'b0, 1);

    for (int n = 0; n < 200; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (n % 4 == 0) a = {a[31], 31'h7FFFFFFF} ^ {1'b0, 31'($urandom_range(0, 3))};
      if (op <= 4'd2 && n % 3 == 0) b[4:0] = 5'd0;
      model(op, a, b, r, ov, il, lt);
      do_op($sformatf("rand%0d op%0d", n, op), op, a, b, r, ov, il, lt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
